alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset. All state changes occur on the rising edge of clk.
REQ-002 Parameter SETTLE_CYCLES, default 1: number of cycles alu_op/alu_a/alu_b are held before alu_result is sampled; legal range 1..4.
REQ-003 clk  in  1  system clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 instr_valid  in  1  instruction offered; instr_ready  out  1  block can accept.
REQ-006 instr  in  32  MIPS instruction word; rs_val  in  32 and rt_val  in  32  register operands, sampled with instr.
REQ-007 alu_op  out  6, alu_a  out  32, alu_b  out  32  registered drive to the ALU operation/a/b inputs.
REQ-008 alu_result  in  32 and alu_zero  in  1  ALU Result and zeroFlag.
REQ-009 res_valid  out  1  response available; res_ready  in  1  consumer accepts.
REQ-010 res_data  out  32, res_zero  out  1, res_wen  out  1 (destination write enable), res_illegal  out  1 (unsupported instruction).

Function
REQ-011 FSM states SHALL be IDLE, EXEC, SAMPLE and RESP; instr_ready SHALL be 1 only in IDLE.
REQ-012 IDLE: on instr_valid&instr_ready, SHALL register instr/rs_val/rt_val, decode, drive alu_op/a/b, load settle counter with SETTLE_CYCLES-1, and go to EXEC.
REQ-013 EXEC: alu_op/a/b SHALL hold constant; counter decrements each cycle; at 0 the FSM goes to SAMPLE.
REQ-014 SAMPLE (one cycle): SHALL register alu_result into res_data and alu_zero into res_zero, then go to RESP with res_valid=1.
REQ-015 Latency: res_valid SHALL assert exactly SETTLE_CYCLES+1 cycles after the accept edge.
REQ-016 RESP: res_valid and all res_* SHALL hold stable until res_valid&res_ready; the FSM then goes to IDLE and res_valid deasserts the next cycle. There is no back-to-back overlap.
REQ-017 R-type (opcode 000000) funct-to-alu_op SHALL be identity for 100000..100111, 101010, 101011, 000000, 000010, 000011, 000100, 000110, 000111, 001010 and 001011.
REQ-018 R-type operands: default a=rs_val, b=rt_val. SLL/SRL: a={27'b0,shamt}, b=rt_val. SRA: a=rt_val, b={27'b0,shamt}. SRAV: a=rt_val, b=rs_val.
REQ-019 SPECIAL2 (opcode 011100): funct 100001 (CLO) -> op 011100; funct 100000 (CLZ) -> op 011101; a=rs_val, b=0.
REQ-020 I-type with a=rs_val, b=imm16 extended:
- addi 001000 -> 100000, sign-extended
- addiu 001001 -> 100001, sign-extended
- slti 001010 -> 101010, sign-extended
- sltiu 001011 -> 101011, sign-extended
- andi 001100 -> 100100, zero-extended
- ori 001101 -> 100101, zero-extended
- xori 001110 -> 100110, zero-extended
REQ-021 beq (000100) SHALL drive op 011111, a=rs_val, b=rt_val; res_data=0, res_zero=alu_zero, res_wen=0.
REQ-022 MOVZ SHALL set res_wen=(rt_val==0); MOVN SHALL set res_wen=(rt_val!=0). When the condition is false, res_data=0.
REQ-023 res_zero SHALL report alu_zero only for ops 100000, 100010, 110111, 001111 and 011111; for all other ops it SHALL be 0.
REQ-024 All other legal ops SHALL have res_wen=1.
REQ-025 Unsupported opcode/funct:
- alu_op=111111, alu_a=0, alu_b=0
- full EXEC/SAMPLE timing still applies
- res_illegal=1, res_wen=0, res_data=0
REQ-026 instr_valid asserted outside IDLE SHALL be ignored; no input is sampled.

Reset
REQ-027 When reset is high at a clock edge, the FSM SHALL enter IDLE and the outputs SHALL take these values on that edge:
- alu_op=111111, alu_a=0, alu_b=0
- res_valid=0, res_data=0, res_zero=0, res_wen=0, res_illegal=0
- settle counter=0
REQ-028 A reset in any state, including mid-EXEC or RESP with res_ready low, SHALL abandon the operation with no response; instr_ready=1 from the first cycle after reset deasserts.

Verification
REQ-029 add: rs=7, rt=0xFFFFFFF9, SETTLE_CYCLES=1 -> alu_op=100000; res_valid two cycles after accept; res_data=0, res_zero=1, res_wen=1.
REQ-030 addi: rs=5, imm=0xFFFF -> alu_b=0xFFFFFFFF, op 100000. andi: imm=0xFFFF -> alu_b=0x0000FFFF, op 100100.
REQ-031 movz: rt=3 -> res_wen=0, res_data=0. movz: rt=0 -> res_wen=1, res_data=rs_val.
REQ-032 Unsupported opcode 111111 -> alu_op=111111, res_illegal=1, res_wen=0. A following valid instruction is accepted normally.
REQ-033 res_ready held low 5 cycles in RESP -> res_* stable and instr_ready=0 throughout; instr_valid pulses during this time are ignored.
REQ-034 SETTLE_CYCLES=3, reset asserted in the second EXEC cycle -> next cycle IDLE, res_valid=0, alu_op=111111, and no response ever appears.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts one MIPS instruction at a time, decodes it onto a
// registered ALU operation/operand interface, holds the operands for
// SETTLE_CYCLES, samples the ALU result and presents it until it is taken.
module alu_issue_ctrl #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instr,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic [5:0]  alu_op,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_zero,
   output logic        res_wen,
   output logic        res_illegal
);

   typedef enum logic [1:0] {IDLE, EXEC, SAMPLE, RESP} stateT;

   // How the sampled ALU result is turned into a response.
   typedef enum logic [2:0] {K_ALU, K_BEQ, K_MOVZ, K_MOVN, K_ILLEGAL} kindT;

   localparam logic [5:0] OP_NONE     = 6'b111111;
   localparam logic [1:0] SETTLE_LOAD = 2'(SETTLE_CYCLES - 1);

   stateT       state, nextState;
   kindT        kind, decKind;
   logic [1:0]  settleCnt;
   logic        rtZero;
   logic [5:0]  decOp;
   logic [31:0] decA, decB;
   logic        accept;
   logic        sampWen;
   logic        zeroOp;

   wire [5:0]  opcode = instr[31:26];
   wire [5:0]  funct  = instr[5:0];
   wire [4:0]  shamt  = instr[10:6];
   wire [15:0] imm    = instr[15:0];

   // Register-number fields are unused: operands arrive already read.
   logic unusedFields;
   assign unusedFields = ^instr[25:16];

   // Decode the offered instruction into ALU op, operands and response kind.
   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      decOp   = OP_NONE;
      decA    = '0;
      decB    = '0;
      decKind = K_ILLEGAL;
      case (opcode)
         6'b000000: begin
            case (funct)
               6'b100000, 6'b100001, 6'b100010, 6'b100011,
               6'b100100, 6'b100101, 6'b100110, 6'b100111,
               6'b101010, 6'b101011, 6'b000100, 6'b000110: begin
                  decOp = funct; decA = rs_val; decB = rt_val; decKind = K_ALU;
               end
               6'b000000, 6'b000010: begin
                  decOp = funct; decA = {27'b0, shamt}; decB = rt_val; decKind = K_ALU;
               end
               6'b000011: begin
                  decOp = funct; decA = rt_val; decB = {27'b0, shamt}; decKind = K_ALU;
               end
               6'b000111: begin
                  decOp = funct; decA = rt_val; decB = rs_val; decKind = K_ALU;
               end
               6'b001010: begin
                  decOp = funct; decA = rs_val; decB = rt_val; decKind = K_MOVZ;
               end
               6'b001011: begin
                  decOp = funct; decA = rs_val; decB = rt_val; decKind = K_MOVN;
               end
               default: ;
            endcase
         end
         6'b011100: begin
            if (funct == 6'b100001 || funct == 6'b100000) begin
               decOp   = (funct == 6'b100001) ? 6'b011100 : 6'b011101;
               decA    = rs_val;
               decKind = K_ALU;
            end
         end
         6'b001000: begin decOp = 6'b100000; decA = rs_val; decB = {{16{imm[15]}}, imm}; decKind = K_ALU; end
         6'b001001: begin decOp = 6'b100001; decA = rs_val; decB = {{16{imm[15]}}, imm}; decKind = K_ALU; end
         6'b001010: begin decOp = 6'b101010; decA = rs_val; decB = {{16{imm[15]}}, imm}; decKind = K_ALU; end
         6'b001011: begin decOp = 6'b101011; decA = rs_val; decB = {{16{imm[15]}}, imm}; decKind = K_ALU; end
         6'b001100: begin decOp = 6'b100100; decA = rs_val; decB = {16'b0, imm}; decKind = K_ALU; end
         6'b001101: begin decOp = 6'b100101; decA = rs_val; decB = {16'b0, imm}; decKind = K_ALU; end
         6'b001110: begin decOp = 6'b100110; decA = rs_val; decB = {16'b0, imm}; decKind = K_ALU; end
         6'b000100: begin decOp = 6'b011111; decA = rs_val; decB = rt_val; decKind = K_BEQ; end
         default: ;
      endcase
   end

   // Response shaping for the SAMPLE cycle: write enable, and which ops expose the zero flag.
   always_comb begin
      case (kind)
         K_ALU:   sampWen = 1'b1;
         K_MOVZ:  sampWen = rtZero;
         K_MOVN:  sampWen = !rtZero;
         default: sampWen = 1'b0;
      endcase
      zeroOp = alu_op inside {6'b100000, 6'b100010, 6'b110111, 6'b001111, 6'b011111};
   end

   // State register.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   // Next-state logic; the block is ready only while idle.
   always_comb begin
      nextState   = state;
      instr_ready = (state == IDLE);
      accept      = 1'b0;
      case (state)
         IDLE: begin
            accept = instr_valid;
            if (instr_valid) nextState = EXEC;
         end
         EXEC:    if (settleCnt == 2'd0) nextState = SAMPLE;
         SAMPLE:  nextState = RESP;
         RESP:    if (res_ready) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Datapath: capture decode on accept, count settle cycles, sample and hold the response.
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_op      <= OP_NONE;
         alu_a       <= '0;
         alu_b       <= '0;
         kind        <= K_ILLEGAL;
         rtZero      <= 1'b0;
         settleCnt   <= '0;
         res_valid   <= 1'b0;
         res_data    <= '0;
         res_zero    <= 1'b0;
         res_wen     <= 1'b0;
         res_illegal <= 1'b0;
      end else begin
         if (accept) begin
            alu_op    <= decOp;
            alu_a     <= decA;
            alu_b     <= decB;
            kind      <= decKind;
            rtZero    <= (rt_val == 32'd0);
            settleCnt <= SETTLE_LOAD;
         end
         if (state == EXEC && settleCnt != 2'd0) settleCnt <= settleCnt - 2'd1;
         if (state == SAMPLE) begin
            res_valid   <= 1'b1;
            res_data    <= sampWen ? alu_result : 32'd0;
            res_zero    <= zeroOp & alu_zero;
            res_wen     <= sampWen;
            res_illegal <= (kind == K_ILLEGAL);
         end
         if (state == RESP && res_ready) res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: one instance at SETTLE_CYCLES=1 for
// decode/response/back-pressure, one at SETTLE_CYCLES=3 for latency and
// reset-during-EXEC behaviour.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        reset, reset3;
   logic        instr_valid, instr_valid3;
   logic [31:0] instr, rs_val, rt_val, alu_result;
   logic        alu_zero;
   logic        res_ready, res_ready3;

   logic        instr_ready, res_valid, res_zero, res_wen, res_illegal;
   logic [5:0]  alu_op;
   logic [31:0] alu_a, alu_b, res_data;

   logic        instr_ready3, res_valid3, res_zero3, res_wen3, res_illegal3;
   logic [5:0]  alu_op3;
   logic [31:0] alu_a3, alu_b3, res_data3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.SETTLE_CYCLES(1)) dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_zero(res_zero), .res_wen(res_wen), .res_illegal(res_illegal)
   );

   alu_issue_ctrl #(.SETTLE_CYCLES(3)) dut3 (
      .clk(clk), .reset(reset3), .instr_valid(instr_valid3), .instr_ready(instr_ready3),
      .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
      .alu_op(alu_op3), .alu_a(alu_a3), .alu_b(alu_b3),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .res_valid(res_valid3), .res_ready(res_ready3), .res_data(res_data3),
      .res_zero(res_zero3), .res_wen(res_wen3), .res_illegal(res_illegal3)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mkR(input logic [5:0] op, input logic [4:0] sh, input logic [5:0] fn);
      return {op, 5'd1, 5'd2, 5'd3, sh, fn};
   endfunction

   function automatic logic [31:0] mkI(input logic [5:0] op, input logic [15:0] im);
      return {op, 5'd1, 5'd2, im};
   endfunction

   // Offer one instruction to the SETTLE_CYCLES=1 instance and follow it into RESP.
   task automatic issueOp(input string name, input logic [31:0] ins, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [31:0] aluRes, input logic aluZ,
                          input logic [5:0] expOp, input logic [31:0] expA, input logic [31:0] expB);
      instr = ins; rs_val = rs; rt_val = rt; alu_result = aluRes; alu_zero = aluZ;
      instr_valid = 1'b1;
      tick;
      instr_valid = 1'b0;
      rs_val = 32'hDEADBEEF; rt_val = 32'hDEADBEEF;
      check({name, ".op"}, 32'(alu_op), 32'(expOp));
      check({name, ".a"}, alu_a, expA);
      check({name, ".b"}, alu_b, expB);
      check({name, ".ready_busy"}, 32'(instr_ready), 32'd0);
      tick;
      check({name, ".valid_early"}, 32'(res_valid), 32'd0);
      tick;
      check({name, ".valid"}, 32'(res_valid), 32'd1);
   endtask

   task automatic expectResp(input string name, input logic [31:0] data, input logic zero,
                             input logic wen, input logic ill);
      check({name, ".data"}, res_data, data);
      check({name, ".zero"}, 32'(res_zero), 32'(zero));
      check({name, ".wen"}, 32'(res_wen), 32'(wen));
      check({name, ".illegal"}, 32'(res_illegal), 32'(ill));
   endtask

   task automatic retire(input string name);
      res_ready = 1'b1;
      tick;
      res_ready = 1'b0;
      check({name, ".valid_drop"}, 32'(res_valid), 32'd0);
      check({name, ".ready_back"}, 32'(instr_ready), 32'd1);
   endtask

   initial begin
      reset = 1'b1; reset3 = 1'b1;
      instr_valid = 1'b0; instr_valid3 = 1'b0;
      res_ready = 1'b0; res_ready3 = 1'b0;
      instr = '0; rs_val = '0; rt_val = '0; alu_result = '0; alu_zero = 1'b0;
      tick;
      tick;
      check("rst.op", 32'(alu_op), 32'h3F);
      check("rst.a", alu_a, 32'd0);
      check("rst.b", alu_b, 32'd0);
      check("rst.valid", 32'(res_valid), 32'd0);
      check("rst.data", res_data, 32'd0);
      check("rst.zero", 32'(res_zero), 32'd0);
      check("rst.wen", 32'(res_wen), 32'd0);
      check("rst.illegal", 32'(res_illegal), 32'd0);
      reset = 1'b0; reset3 = 1'b0;
      tick;
      check("rst.ready", 32'(instr_ready), 32'd1);

      issueOp("add", mkR(6'd0, 5'd0, 6'b100000), 32'd7, 32'hFFFFFFF9, 32'd0, 1'b1,
              6'b100000, 32'd7, 32'hFFFFFFF9);
      expectResp("add", 32'd0, 1'b1, 1'b1, 1'b0);
      retire("add");

      issueOp("addi", mkI(6'b001000, 16'hFFFF), 32'd5, 32'd0, 32'd4, 1'b0,
              6'b100000, 32'd5, 32'hFFFFFFFF);
      expectResp("addi", 32'd4, 1'b0, 1'b1, 1'b0);
      retire("addi");

      issueOp("andi", mkI(6'b001100, 16'hFFFF), 32'h12345678, 32'd0, 32'h5678, 1'b1,
              6'b100100, 32'h12345678, 32'h0000FFFF);
      expectResp("andi", 32'h5678, 1'b0, 1'b1, 1'b0);
      retire("andi");

      issueOp("movz_f", mkR(6'd0, 5'd0, 6'b001010), 32'hAAAA0000, 32'd3, 32'hAAAA0000, 1'b0,
              6'b001010, 32'hAAAA0000, 32'd3);
      expectResp("movz_f", 32'd0, 1'b0, 1'b0, 1'b0);
      retire("movz_f");

      issueOp("movz_t", mkR(6'd0, 5'd0, 6'b001010), 32'hAAAA0000, 32'd0, 32'hAAAA0000, 1'b0,
              6'b001010, 32'hAAAA0000, 32'd0);
      expectResp("movz_t", 32'hAAAA0000, 1'b0, 1'b1, 1'b0);
      retire("movz_t");

      issueOp("movn_t", mkR(6'd0, 5'd0, 6'b001011), 32'h11, 32'd5, 32'h11, 1'b0,
              6'b001011, 32'h11, 32'd5);
      expectResp("movn_t", 32'h11, 1'b0, 1'b1, 1'b0);
      retire("movn_t");

      issueOp("sll", mkR(6'd0, 5'd4, 6'b000000), 32'hDEAD, 32'd3, 32'h30, 1'b0,
              6'b000000, 32'd4, 32'd3);
      expectResp("sll", 32'h30, 1'b0, 1'b1, 1'b0);
      retire("sll");

      issueOp("sra", mkR(6'd0, 5'd2, 6'b000011), 32'h55, 32'h80000000, 32'hE0000000, 1'b0,
              6'b000011, 32'h80000000, 32'd2);
      expectResp("sra", 32'hE0000000, 1'b0, 1'b1, 1'b0);
      retire("sra");

      issueOp("srav", mkR(6'd0, 5'd0, 6'b000111), 32'd5, 32'h100, 32'h8, 1'b0,
              6'b000111, 32'h100, 32'd5);
      expectResp("srav", 32'h8, 1'b0, 1'b1, 1'b0);
      retire("srav");

      issueOp("sub", mkR(6'd0, 5'd0, 6'b100010), 32'd9, 32'd9, 32'd0, 1'b1,
              6'b100010, 32'd9, 32'd9);
      expectResp("sub", 32'd0, 1'b1, 1'b1, 1'b0);
      retire("sub");

      issueOp("beq", mkI(6'b000100, 16'h0010), 32'd9, 32'd9, 32'h55, 1'b1,
              6'b011111, 32'd9, 32'd9);
      expectResp("beq", 32'd0, 1'b1, 1'b0, 1'b0);
      retire("beq");

      issueOp("clz", mkR(6'b011100, 5'd0, 6'b100000), 32'h00F00000, 32'd7, 32'd8, 1'b0,
              6'b011101, 32'h00F00000, 32'd0);
      expectResp("clz", 32'd8, 1'b0, 1'b1, 1'b0);
      retire("clz");

      issueOp("slti", mkI(6'b001010, 16'h8000), 32'd1, 32'd0, 32'd0, 1'b1,
              6'b101010, 32'd1, 32'hFFFF8000);
      expectResp("slti", 32'd0, 1'b0, 1'b1, 1'b0);
      retire("slti");

      issueOp("ill_op", mkI(6'b111111, 16'h1234), 32'd3, 32'd4, 32'h1234, 1'b1,
              6'b111111, 32'd0, 32'd0);
      expectResp("ill_op", 32'd0, 1'b0, 1'b0, 1'b1);
      retire("ill_op");

      issueOp("ill_fn", mkR(6'd0, 5'd0, 6'b000001), 32'd3, 32'd4, 32'h77, 1'b0,
              6'b111111, 32'd0, 32'd0);
      expectResp("ill_fn", 32'd0, 1'b0, 1'b0, 1'b1);
      retire("ill_fn");

      issueOp("ori", mkI(6'b001101, 16'h8001), 32'h10, 32'd0, 32'h8011, 1'b0,
              6'b100101, 32'h10, 32'h00008001);
      expectResp("ori", 32'h8011, 1'b0, 1'b1, 1'b0);
      retire("ori");

      // Back-pressure: hold res_ready low for five cycles while offering instructions.
      issueOp("xor", mkR(6'd0, 5'd0, 6'b100110), 32'hF0, 32'h0F, 32'hFF, 1'b0,
              6'b100110, 32'hF0, 32'h0F);
      for (int i = 0; i < 5; i++) begin
         instr = mkI(6'b001000, 16'h0001);
         rs_val = 32'd100;
         alu_result = 32'h1111;
         instr_valid = 1'b1;
         tick;
         check("bp.valid", 32'(res_valid), 32'd1);
         check("bp.ready", 32'(instr_ready), 32'd0);
         check("bp.op", 32'(alu_op), 32'h26);
         check("bp.a", alu_a, 32'hF0);
         expectResp("bp", 32'hFF, 1'b0, 1'b1, 1'b0);
      end
      instr_valid = 1'b0;
      retire("bp");

      // Reset while holding a response.
      issueOp("rsp_rst", mkR(6'd0, 5'd0, 6'b100001), 32'd1, 32'd1, 32'd2, 1'b0,
              6'b100001, 32'd1, 32'd1);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      check("rsp_rst.valid", 32'(res_valid), 32'd0);
      check("rsp_rst.op", 32'(alu_op), 32'h3F);
      check("rsp_rst.data", res_data, 32'd0);
      tick;
      check("rsp_rst.ready", 32'(instr_ready), 32'd1);

      // SETTLE_CYCLES=3: response four cycles after accept.
      instr = mkR(6'd0, 5'd0, 6'b100000); rs_val = 32'd1; rt_val = 32'd2;
      alu_result = 32'd3; alu_zero = 1'b0;
      instr_valid3 = 1'b1;
      tick;
      instr_valid3 = 1'b0;
      check("s3.op", 32'(alu_op3), 32'h20);
      for (int i = 0; i < 3; i++) begin
         tick;
         check("s3.valid_early", 32'(res_valid3), 32'd0);
      end
      tick;
      check("s3.valid", 32'(res_valid3), 32'd1);
      check("s3.data", res_data3, 32'd3);
      res_ready3 = 1'b1;
      tick;
      res_ready3 = 1'b0;
      check("s3.valid_drop", 32'(res_valid3), 32'd0);

      // SETTLE_CYCLES=3: reset during the second EXEC cycle abandons the operation.
      instr = mkR(6'd0, 5'd0, 6'b100100); rs_val = 32'hFF; rt_val = 32'h0F;
      alu_result = 32'h0F;
      instr_valid3 = 1'b1;
      tick;
      instr_valid3 = 1'b0;
      check("s3r.op_pre", 32'(alu_op3), 32'h24);
      tick;
      reset3 = 1'b1;
      tick;
      reset3 = 1'b0;
      check("s3r.valid", 32'(res_valid3), 32'd0);
      check("s3r.op", 32'(alu_op3), 32'h3F);
      check("s3r.a", alu_a3, 32'd0);
      check("s3r.ready", 32'(instr_ready3), 32'd1);
      for (int i = 0; i < 8; i++) begin
         tick;
         check("s3r.no_resp", 32'(res_valid3), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
